// File: rtl/va_ivc_stage_fsm_pkg.sv
// Shared VC-allocator definitions: per-input-VC stage state encoding and
// index/width helpers.
package vc_alloc_pkg;

  typedef enum logic [1:0] {
    IVC_IDLE   = 2'd0,
    IVC_REQ    = 2'd1,
    IVC_ACTIVE = 2'd2
  } ivc_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Zero-width counters are not expressible, so every width is at least 1 bit.
  function automatic int safe_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int flat_idx(input int p, input int v, input int nv);
    return p * nv + v;
  endfunction

endpackage

// File: rtl/va_ivc_stage_fsm_if.sv
// Bundle between route computation / main allocator and one input-VC
// allocation stage.
interface va_ivc_stage_fsm_if #(
    parameter int NP = 5,
    parameter int NV = 4
);
    logic                 route_valid;
    logic [NP-1:0]        reqPort;
    logic [NV-1:0]        reqVC;
    logic [NP*NV-1:0]     outVCAvailable;
    logic                 vaGrant;
    logic                 tailDone;
    logic [NP*NV-1:0]     reqVCOut;
    logic [NV-1:0]        selOutVC;
    logic                 allocated;
    logic [NP*NV-1:0]     relOutVC;

    modport slave (
        input  route_valid, reqPort, reqVC, outVCAvailable, vaGrant, tailDone,
        output reqVCOut, selOutVC, allocated, relOutVC
    );

    modport master (
        output route_valid, reqPort, reqVC, outVCAvailable, vaGrant, tailDone,
        input  reqVCOut, selOutVC, allocated, relOutVC
    );
endinterface

// File: rtl/va_ivc_stage_fsm_rr_arb_ptr.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo W.
module rr_arb_ptr
    import vc_alloc_pkg::*;
#(
    parameter  int W  = 4,
    localparam int PW = safe_w(W)
) (
    input  logic [W-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [W-1:0]  gnt
);
    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < W; i++) begin
            w_idx = PW'((int'(ptr) + i) % W);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/va_ivc_stage_fsm.sv
// Per-input-VC VC-allocation stage: latches the routed request, keeps a sticky
// candidate toward the main allocator, holds the granted VC until the tail leaves.
module va_ivc_stage_fsm
    import vc_alloc_pkg::*;
#(
    parameter int NP        = 5,
    parameter int NV        = 4,
    parameter int RETRY_MAX = 8
) (
    input  logic            clk,
    input  logic            rstn,
    va_ivc_stage_fsm_if.slave bus
);
    localparam int PW = safe_w(NV);
    localparam int WW = safe_w(RETRY_MAX);

    ivc_state_e     r_state;
    logic [NP-1:0]  r_portQ;
    logic [NV-1:0]  r_vcMaskQ;
    logic [NV-1:0]  r_candQ;
    logic [PW-1:0]  r_ptr;
    logic [WW-1:0]  r_waitCnt;
    logic [NV-1:0]  r_selOutVC;
    logic           r_allocated;
    logic [NP*NV-1:0] r_relOutVC;

    logic [NV-1:0]  w_slice [NP];
    logic [NV-1:0]  w_avail;
    logic [NV-1:0]  w_masked;
    logic [NV-1:0]  w_rr;
    logic [NV-1:0]  w_cand;
    logic [NV-1:0]  w_grant_vc;
    logic [PW-1:0]  w_cand_idx;
    logic [PW-1:0]  w_grant_idx;
    logic [PW-1:0]  w_cand_nxt;
    logic [PW-1:0]  w_grant_nxt;
    logic [NP*NV-1:0] w_rel_vec;
    logic           w_in_req;

    // Port mux: only the latched port's availability slice survives.
    for (genvar gp = 0; gp < NP; gp++) begin : g_port_mux
        assign w_slice[gp] = r_portQ[gp] ? bus.outVCAvailable[flat_idx(gp, 0, NV) +: NV] : '0;
    end

    always_comb begin
        w_avail = '0;
        for (int p = 0; p < NP; p++) w_avail = w_avail | w_slice[p];
    end

    assign w_masked = r_vcMaskQ & w_avail;
    assign w_in_req = (r_state == IVC_REQ);

    rr_arb_ptr #(.W(NV)) u_rr (
        .req (w_masked),
        .ptr (r_ptr),
        .gnt (w_rr)
    );

    // Sticky candidate while still eligible, otherwise replaced in the same cycle.
    assign w_cand = (|(r_candQ & w_masked)) ? r_candQ : w_rr;
    // A grant refers to what was on the wire, so it beats a same-cycle availability drop.
    assign w_grant_vc = (|r_candQ) ? r_candQ : w_cand;

    always_comb begin
        w_cand_idx  = '0;
        w_grant_idx = '0;
        for (int i = 0; i < NV; i++) begin
            if (w_cand[i])     w_cand_idx  = PW'(i);
            if (w_grant_vc[i]) w_grant_idx = PW'(i);
        end
    end

    assign w_cand_nxt  = (w_cand_idx  == PW'(NV - 1)) ? '0 : w_cand_idx  + 1'b1;
    assign w_grant_nxt = (w_grant_idx == PW'(NV - 1)) ? '0 : w_grant_idx + 1'b1;

    for (genvar gp = 0; gp < NP; gp++) begin : g_port_demux
        for (genvar gv = 0; gv < NV; gv++) begin : g_vc
            assign bus.reqVCOut[flat_idx(gp, gv, NV)] = w_in_req & r_portQ[gp] & w_cand[gv];
            assign w_rel_vec[flat_idx(gp, gv, NV)]    = r_portQ[gp] & r_selOutVC[gv];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IVC_IDLE;
            r_portQ     <= '0;
            r_vcMaskQ   <= '0;
            r_candQ     <= '0;
            r_ptr       <= '0;
            r_waitCnt   <= '0;
            r_selOutVC  <= '0;
            r_allocated <= 1'b0;
            r_relOutVC  <= '0;
        end else begin
            r_relOutVC <= '0;
            case (r_state)
                IVC_IDLE: begin
                    if (bus.route_valid && (|bus.reqPort) && (|bus.reqVC)) begin
                        r_portQ   <= bus.reqPort;
                        r_vcMaskQ <= bus.reqVC;
                        r_state   <= IVC_REQ;
                    end
                end
                IVC_REQ: begin
                    if (bus.vaGrant && (|w_grant_vc)) begin
                        r_selOutVC  <= w_grant_vc;
                        r_allocated <= 1'b1;
                        r_ptr       <= w_grant_nxt;
                        r_waitCnt   <= '0;
                        r_candQ     <= '0;
                        r_state     <= IVC_ACTIVE;
                    end else if (|w_cand) begin
                        if (r_waitCnt == WW'(RETRY_MAX - 1)) begin
                            r_ptr     <= w_cand_nxt;
                            r_candQ   <= '0;
                            r_waitCnt <= '0;
                        end else begin
                            r_waitCnt <= r_waitCnt + 1'b1;
                            r_candQ   <= w_cand;
                        end
                    end else begin
                        r_candQ <= '0;
                    end
                end
                IVC_ACTIVE: begin
                    if (bus.tailDone) begin
                        r_relOutVC  <= w_rel_vec;
                        r_selOutVC  <= '0;
                        r_allocated <= 1'b0;
                        r_state     <= IVC_IDLE;
                    end
                end
                default: r_state <= IVC_IDLE;
            endcase
        end
    end

    assign bus.selOutVC  = r_selOutVC;
    assign bus.allocated = r_allocated;
    assign bus.relOutVC  = r_relOutVC;
endmodule

// File: tb/tb_va_ivc_stage_fsm.sv
// Bench for va_ivc_stage_fsm: vector table, directed corner sequences and a
// randomized run against a behavioural model.
module tb_va_ivc_stage_fsm;
    localparam int NP   = 5;
    localparam int NV   = 4;
    localparam int RMAX = 8;
    localparam int NF   = NP * NV;
    localparam logic [NF-1:0] ALL = 20'hFFFFF;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    va_ivc_stage_fsm_if #(.NP(NP), .NV(NV)) bus ();

    va_ivc_stage_fsm #(.NP(NP), .NV(NV), .RETRY_MAX(RMAX)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rv;
        logic [NP-1:0] port;
        logic [NV-1:0] vc;
        logic [NF-1:0] av;
        logic          g;
        logic          t;
        logic [NF-1:0] e_req;
        logic [NV-1:0] e_sel;
        logic          e_alloc;
        logic [NF-1:0] e_rel;
    } vec_t;

    vec_t tbl [12];

    // model state: phase 0 idle, 1 requesting, 2 holding a VC
    int            m_st, m_port, m_cand, m_ptr, m_wait, m_sel;
    logic [NV-1:0] m_mask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [NP-1:0] port, input logic [NV-1:0] vc,
                         input logic [NF-1:0] av, input logic g, input logic t);
        bus.route_valid    = rv;
        bus.reqPort        = port;
        bus.reqVC          = vc;
        bus.outVCAvailable = av;
        bus.vaGrant        = g;
        bus.tailDone       = t;
    endtask

    task automatic cyc(input string nm, input logic [NF-1:0] er, input logic [NV-1:0] es,
                       input logic ea, input logic [NF-1:0] erl);
        #1;
        chk({nm, ".req"}, 32'(bus.reqVCOut), 32'(er));
        @(posedge clk);
        #1;
        chk({nm, ".sel"}, 32'(bus.selOutVC), 32'(es));
        chk({nm, ".alloc"}, 32'(bus.allocated), 32'(ea));
        chk({nm, ".rel"}, 32'(bus.relOutVC), 32'(erl));
    endtask

    task automatic reset_dut(input string nm);
        rstn = 1'b0;
        #1;
        chk({nm, ".req"}, 32'(bus.reqVCOut), 32'd0);
        chk({nm, ".sel"}, 32'(bus.selOutVC), 32'd0);
        chk({nm, ".alloc"}, 32'(bus.allocated), 32'd0);
        chk({nm, ".rel"}, 32'(bus.relOutVC), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        m_st = 0; m_port = 0; m_cand = -1; m_ptr = 0; m_wait = 0; m_sel = -1; m_mask = '0;
    endtask

    function automatic int first_from(input logic [NV-1:0] m, input int p);
        for (int i = 0; i < NV; i++) begin
            if (m[(p + i) % NV]) return (p + i) % NV;
        end
        return -1;
    endfunction

    // One clock of the reference model: request seen now, registered outputs after the edge.
    task automatic model_step(output logic [NF-1:0] er, output logic [NV-1:0] es,
                              output logic ea, output logic [NF-1:0] erl);
        logic [NV-1:0] masked;
        int cand, g;
        er = '0; erl = '0; cand = -1;
        if (m_st == 1) begin
            masked = m_mask & NV'(bus.outVCAvailable >> (m_port * NV));
            if (m_cand >= 0 && masked[m_cand]) cand = m_cand;
            else cand = first_from(masked, m_ptr);
            if (cand >= 0) er[m_port * NV + cand] = 1'b1;
            g = (m_cand >= 0) ? m_cand : cand;
            if (bus.vaGrant && g >= 0) begin
                m_sel = g; m_ptr = (g + 1) % NV; m_wait = 0; m_cand = -1; m_st = 2;
            end else if (cand >= 0) begin
                if (m_wait == RMAX - 1) begin
                    m_ptr = (cand + 1) % NV; m_cand = -1; m_wait = 0;
                end else begin
                    m_wait++; m_cand = cand;
                end
            end else begin
                m_cand = -1;
            end
        end else if (m_st == 0) begin
            if (bus.route_valid && bus.reqPort != 0 && bus.reqVC != 0) begin
                for (int p = 0; p < NP; p++) if (bus.reqPort[p]) m_port = p;
                m_mask = bus.reqVC;
                m_st   = 1;
            end
        end else if (bus.tailDone) begin
            erl[m_port * NV + m_sel] = 1'b1;
            m_sel = -1;
            m_st  = 0;
        end
        es = (m_sel >= 0) ? NV'(1 << m_sel) : '0;
        ea = (m_sel >= 0);
    endtask

    initial begin
        logic [NF-1:0] er, erl;
        logic [NV-1:0] es;
        logic          ea;
        logic [NP-1:0] rp;

        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        reset_dut("reset0");

        tbl[0]  = '{1'b1, 5'b00100, 4'b0110, ALL,       1'b0, 1'b0, 20'h0,     4'b0000, 1'b0, 20'h0};
        tbl[1]  = '{1'b0, 5'b00000, 4'b0000, ALL,       1'b1, 1'b0, 20'h00200, 4'b0010, 1'b1, 20'h0};
        tbl[2]  = '{1'b0, 5'b00000, 4'b0000, ALL,       1'b0, 1'b0, 20'h0,     4'b0010, 1'b1, 20'h0};
        tbl[3]  = '{1'b1, 5'b00001, 4'b1111, ALL,       1'b0, 1'b1, 20'h0,     4'b0000, 1'b0, 20'h00200};
        tbl[4]  = '{1'b0, 5'b00000, 4'b0000, ALL,       1'b0, 1'b0, 20'h0,     4'b0000, 1'b0, 20'h0};
        tbl[5]  = '{1'b1, 5'b00010, 4'b1000, ALL,       1'b0, 1'b0, 20'h0,     4'b0000, 1'b0, 20'h0};
        tbl[6]  = '{1'b0, 5'b00000, 4'b0000, 20'hFFF7F, 1'b1, 1'b0, 20'h0,     4'b0000, 1'b0, 20'h0};
        tbl[7]  = '{1'b0, 5'b00000, 4'b0000, ALL,       1'b0, 1'b0, 20'h00080, 4'b0000, 1'b0, 20'h0};
        tbl[8]  = '{1'b0, 5'b00000, 4'b0000, ALL,       1'b1, 1'b0, 20'h00080, 4'b1000, 1'b1, 20'h0};
        tbl[9]  = '{1'b0, 5'b00000, 4'b0000, ALL,       1'b0, 1'b1, 20'h0,     4'b0000, 1'b0, 20'h00080};
        tbl[10] = '{1'b1, 5'b10000, 4'b0000, ALL,       1'b0, 1'b0, 20'h0,     4'b0000, 1'b0, 20'h0};
        tbl[11] = '{1'b0, 5'b00000, 4'b0000, ALL,       1'b0, 1'b0, 20'h0,     4'b0000, 1'b0, 20'h0};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rv, tbl[i].port, tbl[i].vc, tbl[i].av, tbl[i].g, tbl[i].t);
            cyc($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_sel, tbl[i].e_alloc, tbl[i].e_rel);
        end

        // Candidate loss, sticky hold, then grant colliding with the candidate's drop.
        reset_dut("reset1");
        drive(1'b1, 5'b00100, 4'b0110, ALL, 1'b0, 1'b0);
        cyc("loss.head", 20'h0, 4'b0000, 1'b0, 20'h0);
        drive(1'b0, '0, '0, ALL, 1'b0, 1'b0);
        cyc("loss.first", 20'h00200, 4'b0000, 1'b0, 20'h0);
        drive(1'b0, '0, '0, ALL & ~20'h00200, 1'b0, 1'b0);
        cyc("loss.swap", 20'h00400, 4'b0000, 1'b0, 20'h0);
        drive(1'b0, '0, '0, ALL, 1'b0, 1'b0);
        cyc("loss.sticky", 20'h00400, 4'b0000, 1'b0, 20'h0);
        drive(1'b0, '0, '0, ALL & ~20'h00400, 1'b1, 1'b0);
        cyc("collide", 20'h00200, 4'b0100, 1'b1, 20'h0);
        drive(1'b1, 5'b00100, 4'b0110, ALL, 1'b0, 1'b1);
        cyc("release", 20'h0, 4'b0000, 1'b0, 20'h00400);
        drive(1'b0, '0, '0, ALL, 1'b0, 1'b0);
        cyc("release.idle", 20'h0, 4'b0000, 1'b0, 20'h0);

        // Retry rotation after RMAX losing cycles, then reset in the middle of REQ.
        reset_dut("reset2");
        drive(1'b1, 5'b00100, 4'b0110, ALL, 1'b0, 1'b0);
        cyc("retry.head", 20'h0, 4'b0000, 1'b0, 20'h0);
        drive(1'b0, '0, '0, 20'h00600, 1'b0, 1'b0);
        for (int i = 0; i < RMAX + 2; i++) begin
            cyc($sformatf("retry%0d", i), (i < RMAX) ? 20'h00200 : 20'h00400, 4'b0000, 1'b0, 20'h0);
        end
        reset_dut("reset.midreq");
        drive(1'b1, 5'b00100, 4'b1111, ALL, 1'b0, 1'b0);
        cyc("post.head", 20'h0, 4'b0000, 1'b0, 20'h0);
        drive(1'b0, '0, '0, ALL, 1'b0, 1'b0);
        cyc("post.ptr0", 20'h00100, 4'b0000, 1'b0, 20'h0);

        // Randomized traffic against the reference model.
        reset_dut("reset3");
        for (int n = 0; n < 2000; n++) begin
            rp = ($urandom_range(0, 9) == 0) ? '0 : NP'(1 << $urandom_range(0, NP - 1));
            drive($urandom_range(0, 3) == 0, rp, NV'($urandom_range(0, 15)),
                  NF'($urandom | $urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            model_step(er, es, ea, erl);
            cyc("rnd", er, es, ea, erl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/va_ivc_stage_fsm.md
# va_ivc_stage_fsm

Parametrised per-input-VC stage of the VC allocator, generalised to NP ports and NV VCs. It latches the routed request for a head flit, masks it with output-VC availability, and holds one sticky candidate toward the main allocator. After the candidate loses for RETRY_MAX consecutive cycles, it rotates to the next eligible VC. On grant it holds the allocated output VC until the tail flit leaves, then returns that VC with a release pulse. One instance sits per input VC, between route computation and the separable main allocator.

## Interface
- NP, 5, number of router ports.
- NV, 4, VCs per port.
- RETRY_MAX, 8, consecutive non-granted REQ cycles before candidate rotation; must be ≥1.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- route_valid  in  1  head flit routed; reqPort/reqVC valid this cycle.
- reqPort  in  NP  one-hot output port from route computation.
- reqVC  in  NV  permitted output-VC mask (class).
- outVCAvailable  in  NP*NV  availability; bit p*NV+v = port p VC v free.
- vaGrant  in  1  main allocator granted this stage's current request.
- tailDone  in  1  tail flit of the allocated packet has departed.
- reqVCOut  out  NP*NV  one-hot (or zero) request to main allocator; bit p*NV+v.
- selOutVC  out  NV  one-hot allocated output VC (registered).
- allocated  out  1  selOutVC valid.
- relOutVC  out  NP*NV  one-cycle release pulse of the freed output VC.

## Operation
- States: IDLE, REQ, ACTIVE. Reset state IDLE.
- Registered on reset: portQ = 0, vcMaskQ = 0, candQ = 0, ptr = 0, waitCnt = 0, selOutVC = 0, allocated = 0, relOutVC = 0.
- Combinational reqVCOut = 0 outside REQ.
- IDLE: when route_valid=1 with reqPort≠0 and reqVC≠0, latch portQ/vcMaskQ and move to REQ. Otherwise, including a zero port or mask, stay in IDLE.
- REQ masking: avail = outVCAvailable slice selected by portQ; masked = vcMaskQ & avail.
- REQ arbitration: if candQ is still set in masked, keep candQ (sticky). Otherwise choose a new candidate combinationally by round-robin from ptr over masked. If masked=0, request nothing.
- REQ output: reqVCOut = candidate placed at port portQ.
- REQ on vaGrant=1 while a candidate is asserted:
  - selOutVC ← candidate; allocated ← 1.
  - ptr ← candidate index + 1 mod NV.
  - waitCnt ← 0; candQ ← 0; go to ACTIVE.
  - Grant takes priority over a same-cycle availability drop.
- REQ on vaGrant=0 with a candidate asserted:
  - If waitCnt = RETRY_MAX-1: ptr ← candidate+1, candQ ← 0 (forced re-arbitration next cycle), waitCnt ← 0.
  - Otherwise waitCnt++ and candQ ← candidate.
- REQ with masked=0: waitCnt holds.
- vaGrant with no candidate asserted is ignored.
- ACTIVE: reqVCOut=0, selOutVC/allocated held. On tailDone=1: relOutVC ← selOutVC at port portQ for one cycle; selOutVC, allocated ← 0; go to IDLE.
- Ignored inputs: route_valid in REQ/ACTIVE, and tailDone in IDLE/REQ.
- A route_valid coinciding with tailDone is ignored because the FSM is still in ACTIVE.

## Timing
- route_valid at cycle t → REQ at t+1; reqVCOut valid combinationally in t+1 when masked≠0.
- vaGrant at cycle g → allocated=1, selOutVC valid at g+1; reqVCOut=0 from g+1.
- A lost candidate (availability drop) is replaced in the same cycle; no bubble.
- tailDone at cycle d → relOutVC pulse and IDLE at d+1; a new route_valid is accepted from d+1.
- Minimum head-to-allocation latency: 2 cycles.
- Asynchronous reset mid-operation: all registers clear immediately and reqVCOut drops to 0 without a clock edge. Previously held VCs are not released; the system-level reset covers them.
- waitCnt width: clog2(RETRY_MAX); ptr width: clog2(NV).

## Structure
- Shared package vc_alloc_pkg:
  - state encoding localparams IVC_IDLE/IVC_REQ/IVC_ACTIVE;
  - flat-index helper p*NV+v;
  - clog2 function.
- Sub-module rr_arb_ptr (parameter W): inputs req[W], ptr; output one-hot gnt. Purely combinational.
- Pointer and sticky logic stay in this block.
- Port mux and demux are parametrised generate loops.

## Test plan
- Reset: assert rstn=0 mid-REQ → reqVCOut, selOutVC, allocated, relOutVC all 0 immediately. After release, IDLE with ptr=0.
- Basic allocation (NP=5, NV=4): route_valid, reqPort=5'b00100, reqVC=4'b0110, all available → next cycle reqVCOut bit 9. vaGrant → selOutVC=4'b0010, allocated=1 one cycle later.
- Candidate loss: in REQ with candidate bit 9, drop outVCAvailable[9] → same cycle reqVCOut=bit 10, no idle cycle.
- Retry rotation: RETRY_MAX=8, bits 9 and 10 available, no grant → reqVCOut=bit 9 for 8 cycles, then bit 10 on the 9th.
- Release: tailDone in ACTIVE with route_valid also high → relOutVC bit 9 pulses exactly one cycle, allocated=0, state IDLE. The route_valid is not latched.
- Grant/availability collision: vaGrant and drop of the candidate's availability in the same cycle → grant honoured, selOutVC = dropped candidate.
